// File: rtl/l2_cache_wb.sv
// N-way set-associative write-back, write-allocate L2 cache with true-LRU replacement,
// dirty-victim eviction and whole-cache flush; block-granular L1 and memory interfaces.
module l2_cache_wb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11,
  parameter int CACHE_SIZE = 512,
  parameter int BLOCK_SIZE = 32,
  parameter int NUM_WAYS   = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [ADDR_WIDTH-1:0]              l1_cache_addr,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0]   l1_cache_data_in,
  input  logic                               l1_cache_read,
  input  logic                               l1_cache_write,
  input  logic                               l1_flush,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0]   l1_block_data_out,
  output logic                               l1_block_valid,
  output logic                               l1_cache_ready,
  output logic                               l1_cache_hit,
  output logic                               l1_busy,
  output logic                               flush_done,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0]   mem_data_block,
  input  logic                               mem_ready,
  output logic [ADDR_WIDTH-1:0]              mem_addr,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0]   mem_data_out,
  output logic                               mem_read,
  output logic                               mem_write
);

  localparam int NUM_SETS  = CACHE_SIZE / NUM_WAYS;
  localparam int SET_BITS  = $clog2(NUM_SETS);
  localparam int WAY_BITS  = $clog2(NUM_WAYS);
  localparam int TAG_BITS  = ADDR_WIDTH - SET_BITS;
  localparam int LINE_BITS = SET_BITS + WAY_BITS;
  localparam int BW        = BLOCK_SIZE * DATA_WIDTH;
  localparam int AGE_W     = NUM_WAYS * WAY_BITS;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOOKUP     = 3'd1,
    WRITEBACK  = 3'd2,
    REFILL     = 3'd3,
    RESPOND    = 3'd4,
    FLUSH_SCAN = 3'd5,
    FLUSH_WB   = 3'd6
  } state_t;

  function automatic logic [AGE_W-1:0] age_init();
    logic [AGE_W-1:0] a;
    a = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      a[w*WAY_BITS +: WAY_BITS] = WAY_BITS'(w);
    end
    return a;
  endfunction

  // Accessed way becomes youngest; ways younger than its old age each get one step older.
  function automatic logic [AGE_W-1:0] age_touch(input logic [AGE_W-1:0] a,
                                                  input logic [WAY_BITS-1:0] way);
    logic [WAY_BITS-1:0] old_age;
    logic [WAY_BITS-1:0] cur;
    logic [AGE_W-1:0]    n;
    old_age = a[way*WAY_BITS +: WAY_BITS];
    n = a;
    for (int w = 0; w < NUM_WAYS; w++) begin
      cur = a[w*WAY_BITS +: WAY_BITS];
      if (WAY_BITS'(w) == way) begin
        n[w*WAY_BITS +: WAY_BITS] = '0;
      end else if (cur < old_age) begin
        n[w*WAY_BITS +: WAY_BITS] = cur + WAY_BITS'(1);
      end else begin
        n[w*WAY_BITS +: WAY_BITS] = cur;
      end
    end
    return n;
  endfunction

  localparam logic [AGE_W-1:0] AGE_INIT = age_init();

  logic [BW-1:0]         data_mem [CACHE_SIZE];
  logic [TAG_BITS-1:0]   tag_mem  [CACHE_SIZE];
  logic [CACHE_SIZE-1:0] valid_r;
  logic [CACHE_SIZE-1:0] dirty_r;
  logic [AGE_W-1:0]      age_r    [NUM_SETS];

  state_t                state_r, next_state_s;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [BW-1:0]         wdata_r;
  logic                  op_wr_r;
  logic                  hit_r;
  logic [WAY_BITS-1:0]   victim_r;
  logic [LINE_BITS-1:0]  scan_r;

  logic [SET_BITS-1:0]   req_set_s;
  logic [TAG_BITS-1:0]   req_tag_s;
  logic                  hit_s;
  logic [WAY_BITS-1:0]   hit_way_s;
  logic                  inv_found_s;
  logic [WAY_BITS-1:0]   inv_way_s;
  logic [WAY_BITS-1:0]   lru_way_s;
  logic [WAY_BITS-1:0]   victim_s;

  logic                  inst_en_s;
  logic [WAY_BITS-1:0]   inst_way_s;
  logic [BW-1:0]         inst_data_s;
  logic                  inst_dirty_s;
  logic                  touch_en_s;
  logic [WAY_BITS-1:0]   touch_way_s;
  logic                  wb_done_s;
  logic                  scan_clear_s;
  logic                  flush_clr_s;

  logic [BW-1:0]         blk_out_r;
  logic                  blk_valid_r, ready_r, hit_out_r, busy_r, flush_done_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic [BW-1:0]         mem_data_out_r;
  logic                  mem_read_r, mem_write_r;

  assign req_set_s = addr_r[SET_BITS-1:0];
  assign req_tag_s = addr_r[ADDR_WIDTH-1:SET_BITS];

  // Tag compare across the set and victim selection (lowest invalid way, else oldest).
  always_comb begin
    hit_s       = 1'b0;
    hit_way_s   = '0;
    inv_found_s = 1'b0;
    inv_way_s   = '0;
    lru_way_s   = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid_r[{req_set_s, WAY_BITS'(w)}] && (tag_mem[{req_set_s, WAY_BITS'(w)}] == req_tag_s)) begin
        hit_s     = 1'b1;
        hit_way_s = WAY_BITS'(w);
      end else begin
        hit_s     = hit_s;
      end
      if (!valid_r[{req_set_s, WAY_BITS'(w)}]) begin
        inv_found_s = 1'b1;
        inv_way_s   = WAY_BITS'(w);
      end else begin
        inv_found_s = inv_found_s;
      end
      if (age_r[req_set_s][w*WAY_BITS +: WAY_BITS] == WAY_BITS'(NUM_WAYS - 1)) begin
        lru_way_s = WAY_BITS'(w);
      end else begin
        lru_way_s = lru_way_s;
      end
    end
    victim_s = inv_found_s ? inv_way_s : lru_way_s;
  end

  // Next-state logic and array update strobes.
  always_comb begin
    next_state_s = state_r;
    inst_en_s    = 1'b0;
    inst_way_s   = victim_r;
    inst_data_s  = wdata_r;
    inst_dirty_s = 1'b0;
    touch_en_s   = 1'b0;
    touch_way_s  = victim_r;
    wb_done_s    = 1'b0;
    scan_clear_s = 1'b0;
    flush_clr_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (l1_flush) begin
          next_state_s = FLUSH_SCAN;
        end else if (l1_cache_write || l1_cache_read) begin
          next_state_s = LOOKUP;
        end else begin
          next_state_s = IDLE;
        end
      end
      LOOKUP: begin
        if (hit_s) begin
          inst_en_s    = op_wr_r;
          inst_way_s   = hit_way_s;
          inst_dirty_s = 1'b1;
          touch_en_s   = 1'b1;
          touch_way_s  = hit_way_s;
          next_state_s = RESPOND;
        end else if (valid_r[{req_set_s, victim_s}] && dirty_r[{req_set_s, victim_s}]) begin
          next_state_s = WRITEBACK;
        end else if (op_wr_r) begin
          inst_en_s    = 1'b1;
          inst_way_s   = victim_s;
          inst_dirty_s = 1'b1;
          touch_en_s   = 1'b1;
          touch_way_s  = victim_s;
          next_state_s = RESPOND;
        end else begin
          next_state_s = REFILL;
        end
      end
      WRITEBACK: begin
        if (mem_ready) begin
          wb_done_s = 1'b1;
          if (op_wr_r) begin
            inst_en_s    = 1'b1;
            inst_dirty_s = 1'b1;
            touch_en_s   = 1'b1;
            next_state_s = RESPOND;
          end else begin
            next_state_s = REFILL;
          end
        end else begin
          next_state_s = WRITEBACK;
        end
      end
      REFILL: begin
        if (mem_ready) begin
          inst_en_s    = 1'b1;
          inst_data_s  = mem_data_block;
          touch_en_s   = 1'b1;
          next_state_s = RESPOND;
        end else begin
          next_state_s = REFILL;
        end
      end
      RESPOND: begin
        next_state_s = IDLE;
      end
      FLUSH_SCAN: begin
        if (valid_r[scan_r] && dirty_r[scan_r]) begin
          next_state_s = FLUSH_WB;
        end else begin
          scan_clear_s = 1'b1;
          if (scan_r == LINE_BITS'(CACHE_SIZE - 1)) begin
            next_state_s = IDLE;
          end else begin
            next_state_s = FLUSH_SCAN;
          end
        end
      end
      FLUSH_WB: begin
        if (mem_ready) begin
          flush_clr_s  = 1'b1;
          next_state_s = FLUSH_SCAN;
        end else begin
          next_state_s = FLUSH_WB;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State register and latched request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      addr_r   <= '0;
      wdata_r  <= '0;
      op_wr_r  <= 1'b0;
      hit_r    <= 1'b0;
      victim_r <= '0;
      scan_r   <= '0;
    end else begin
      state_r <= next_state_s;
      if (state_r == IDLE && next_state_s == LOOKUP) begin
        addr_r  <= l1_cache_addr;
        wdata_r <= l1_cache_data_in;
        op_wr_r <= l1_cache_write;
      end
      if (state_r == LOOKUP) begin
        hit_r    <= hit_s;
        victim_r <= victim_s;
      end
      if (state_r == IDLE) begin
        scan_r <= '0;
      end else if (scan_clear_s) begin
        scan_r <= scan_r + LINE_BITS'(1);
      end
    end
  end

  // Valid, dirty and LRU-age state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= '0;
      dirty_r <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        age_r[s] <= AGE_INIT;
      end
    end else begin
      if (wb_done_s) begin
        dirty_r[{req_set_s, victim_r}] <= 1'b0;
      end
      if (inst_en_s) begin
        valid_r[{req_set_s, inst_way_s}] <= 1'b1;
        dirty_r[{req_set_s, inst_way_s}] <= inst_dirty_s;
      end
      if (touch_en_s) begin
        age_r[req_set_s] <= age_touch(age_r[req_set_s], touch_way_s);
      end
      if (flush_clr_s) begin
        dirty_r[scan_r] <= 1'b0;
      end
      if (scan_clear_s) begin
        valid_r[scan_r] <= 1'b0;
        dirty_r[scan_r] <= 1'b0;
        age_r[scan_r[LINE_BITS-1:WAY_BITS]][scan_r[WAY_BITS-1:0]*WAY_BITS +: WAY_BITS] <= scan_r[WAY_BITS-1:0];
      end
    end
  end

  // Block data and tag storage (contents are meaningless until the valid bit is set).
  always_ff @(posedge clk) begin
    if (inst_en_s) begin
      data_mem[{req_set_s, inst_way_s}] <= inst_data_s;
      tag_mem[{req_set_s, inst_way_s}]  <= req_tag_s;
    end
  end

  // Registered L1 and memory-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_out_r      <= '0;
      blk_valid_r    <= 1'b0;
      ready_r        <= 1'b0;
      hit_out_r      <= 1'b0;
      busy_r         <= 1'b0;
      flush_done_r   <= 1'b0;
      mem_addr_r     <= '0;
      mem_data_out_r <= '0;
      mem_read_r     <= 1'b0;
      mem_write_r    <= 1'b0;
    end else begin
      ready_r      <= (state_r == RESPOND);
      hit_out_r    <= (state_r == RESPOND) && hit_r;
      blk_valid_r  <= (state_r == RESPOND) && !op_wr_r;
      busy_r       <= (next_state_s != IDLE);
      flush_done_r <= (state_r == FLUSH_SCAN) && (next_state_s == IDLE);
      mem_read_r   <= (next_state_s == REFILL);
      mem_write_r  <= (next_state_s == WRITEBACK) || (next_state_s == FLUSH_WB);
      if (state_r == LOOKUP && hit_s && !op_wr_r) begin
        blk_out_r <= data_mem[{req_set_s, hit_way_s}];
      end else if (state_r == REFILL && mem_ready) begin
        blk_out_r <= mem_data_block;
      end
      if (state_r == LOOKUP && next_state_s == WRITEBACK) begin
        mem_addr_r     <= {tag_mem[{req_set_s, victim_s}], req_set_s};
        mem_data_out_r <= data_mem[{req_set_s, victim_s}];
      end else if (state_r == FLUSH_SCAN && next_state_s == FLUSH_WB) begin
        mem_addr_r     <= {tag_mem[scan_r], scan_r[LINE_BITS-1:WAY_BITS]};
        mem_data_out_r <= data_mem[scan_r];
      end else if (next_state_s == REFILL && state_r != REFILL) begin
        mem_addr_r <= addr_r;
      end
    end
  end

  assign l1_block_data_out = blk_out_r;
  assign l1_block_valid    = blk_valid_r;
  assign l1_cache_ready    = ready_r;
  assign l1_cache_hit      = hit_out_r;
  assign l1_busy           = busy_r;
  assign flush_done        = flush_done_r;
  assign mem_addr          = mem_addr_r;
  assign mem_data_out      = mem_data_out_r;
  assign mem_read          = mem_read_r;
  assign mem_write         = mem_write_r;

endmodule

// File: doc/l2_cache_wb.md
Name: l2_cache_wb

Overview:
Parametrised successor to the current L2 cache. It is an N-way set-associative, write-back, write-allocate L2 with true-LRU replacement, dirty-victim eviction and a whole-cache flush. It sits between the L1 (block-granular requests) and main memory (block-granular read/write handshake). All transfers are full blocks.

Parameters:
DATA_WIDTH, 32, bits per word
ADDR_WIDTH, 11, block-address width (each address names one block)
CACHE_SIZE, 512, total blocks; NUM_SETS = CACHE_SIZE/NUM_WAYS (power of 2)
BLOCK_SIZE, 32, words per block; BW = BLOCK_SIZE*DATA_WIDTH
NUM_WAYS, 4, associativity (power of 2, >=2)

Ports:
clk  in  1  sole clock, rising edge
rst  in  1  asynchronous, active-high reset
l1_cache_addr  in  ADDR_WIDTH  block address; index = low log2(NUM_SETS) bits, tag = remainder
l1_cache_data_in  in  BW  write block, flattened, word 0 in LSBs
l1_cache_read  in  1  read request, sampled in IDLE only
l1_cache_write  in  1  write request, sampled in IDLE only
l1_flush  in  1  write back all dirty lines, then invalidate all
l1_block_data_out  out  BW  read block
l1_block_valid  out  1  l1_block_data_out valid (reads only)
l1_cache_ready  out  1  one-cycle completion pulse for read/write
l1_cache_hit  out  1  qualified by ready: request hit
l1_busy  out  1  high whenever state != IDLE
flush_done  out  1  one-cycle pulse at flush completion
mem_data_block  in  BW  memory read data, valid with mem_ready during read
mem_ready  in  1  memory completes current mem_read/mem_write this cycle
mem_addr  out  ADDR_WIDTH  block address to memory
mem_data_out  out  BW  write-back block
mem_read  out  1  level, held until mem_ready
mem_write  out  1  level, held until mem_ready

Behaviour:
- Reset: all outputs 0; state IDLE; valid and dirty cleared; LRU age of way w = w in every set. Data and tag arrays are not reset. Reset mid-transaction aborts it; memory handshake is dropped.
- States: IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND, FLUSH_SCAN, FLUSH_WB.
- IDLE: priority is l1_flush > write > read (read+write together = write). Latch addr, data and op; go to LOOKUP (or FLUSH_SCAN). Requests outside IDLE are ignored.
- LOOKUP (1 cycle): tag compare on all valid ways.
  - Hit, read: output way data.
  - Hit, write: store block, set dirty.
  - Either hit: update LRU; go to RESPOND with hit=1.
  - Miss: victim = lowest-index invalid way, else way with age NUM_WAYS-1.
  - Victim valid and dirty: go to WRITEBACK. Otherwise read goes to REFILL; write installs block (valid, dirty) then RESPOND.
- WRITEBACK: mem_write=1, mem_addr={victim tag,index}, mem_data_out=victim block. On mem_ready: clear dirty; read goes to REFILL, write installs then RESPOND.
- REFILL: mem_read=1, mem_addr=request addr. On mem_ready: install mem_data_block (valid, clean), forward it to l1_block_data_out, go to RESPOND.
- No write-through: mem_write is asserted only for dirty evictions and flush.
- Any install updates LRU.
- RESPOND: l1_cache_ready=1 for one cycle; l1_block_valid=1 for reads; l1_cache_hit per lookup; return to IDLE. l1_block_data_out holds until the next read response.
- Hit latency: request sampled at edge N, ready high in cycle after edge N+2.
- LRU update: accessed way age becomes 0; ways whose age is below the old age increment by 1; ages stay a permutation.
- Flush:
  - FLUSH_SCAN walks a set/way counter from 0.
  - A dirty valid line goes to FLUSH_WB (mem_write, same rules as WRITEBACK); on mem_ready, return to FLUSH_SCAN.
  - Each visited line is invalidated; LRU is reset to w.
  - After the last line: flush_done pulse, go to IDLE.
  - A clean cache takes CACHE_SIZE scan cycles.
- mem_ready outside a mem_read/mem_write cycle is ignored.

Test Plan:
- Read miss clean, addr 0x00A, memory returns word i = 0xDEADBEEF^i → mem_read with mem_addr 0x00A, no mem_write; ready pulse with hit=0, valid=1, word0=0xDEADBEEF.
- Read 0x00A again → ready with hit=1, word0=0xDEADBEEF, no memory activity; ready in cycle after edge N+2.
- Write miss 0x014 with data 0xA5A5A5A5^i → no mem_read, no mem_write, ready with hit=0. Then read 0x014 → hit=1, word3=0xA5A5A5A6.
- LRU eviction: write 0x00B, then read 0x08B, 0x10B, 0x18B, then 0x20B (same set, tag 4) → mem_write with mem_addr 0x00B and the written data, then mem_read 0x20B; re-read 0x08B hits.
- Flush with two dirty lines → exactly two mem_write transactions, then flush_done pulse. Re-reading either address misses with no mem_write.
- Assert rst during REFILL with mem_read high → all outputs 0 immediately. Read 0x00A afterward misses.
